// File: rtl/mult_result_bcd.sv
// Captures the multiplier's magnitude/sign on start and converts the magnitude to NDIG BCD digits,
// one bit per clock (shift-add-3). Optional leading-zero blanking: define MULT_BCD_BLANK_EN.
module mult_result_bcd #(
  parameter int D2W  = 16,
  parameter int NDIG = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [D2W-1:0]    product,
  input  logic              sign,
  output logic              busy,
  output logic              done,
  output logic [4*NDIG-1:0] bcd,
  output logic              sign_out
);

  localparam int BW = 4 * NDIG;
  localparam int CW = $clog2(D2W + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(D2W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]     state_reg;
  logic [D2W-1:0] bin_reg;
  logic [BW-1:0]  scratch_reg;
  logic [CW-1:0]  cnt_reg;
  logic           sign_reg;
  logic [BW-1:0]  bcd_reg;
  logic           sign_out_reg;
  logic           done_reg;

  logic [BW-1:0]  scratch_adj;
  logic [BW-1:0]  bcd_next;

  // Every digit is corrected from its pre-shift value, all digits in parallel.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_adj
    assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                  ? scratch_reg[4*gi +: 4] + 4'd3
                                  : scratch_reg[4*gi +: 4];
  end

`ifdef MULT_BCD_BLANK_EN
  // lz[i] is set when digit i and every digit above it are zero.
  logic [NDIG:0] lz;
  assign lz[NDIG] = 1'b1;
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_blank
    assign lz[gi] = lz[gi+1] & (scratch_reg[4*gi +: 4] == 4'd0);
    if (gi == 0) begin : g_units
      assign bcd_next[3:0] = scratch_reg[3:0];
    end else begin : g_upper
      assign bcd_next[4*gi +: 4] = lz[gi] ? 4'hF : scratch_reg[4*gi +: 4];
    end
  end
`else
  assign bcd_next = scratch_reg;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      bin_reg      <= '0;
      scratch_reg  <= '0;
      cnt_reg      <= '0;
      sign_reg     <= 1'b0;
      bcd_reg      <= '0;
      sign_out_reg <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            bin_reg     <= product;
            scratch_reg <= '0;
            cnt_reg     <= '0;
            // A zero product never shows a minus sign.
            sign_reg    <= sign & (|product);
            state_reg   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          scratch_reg <= {scratch_adj[BW-2:0], bin_reg[D2W-1]};
          bin_reg     <= {bin_reg[D2W-2:0], 1'b0};
          cnt_reg     <= cnt_reg + CW'(1);
          if (cnt_reg == LAST_SHIFT) begin
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          bcd_reg      <= bcd_next;
          sign_out_reg <= sign_reg;
          done_reg     <= 1'b1;
          state_reg    <= S_IDLE;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = (state_reg != S_IDLE);
  assign done     = done_reg;
  assign bcd      = bcd_reg;
  assign sign_out = sign_out_reg;

endmodule

// File: tb/tb_mult_result_bcd.sv
// Bench for mult_result_bcd: latency-based reference model checked every cycle, directed literal
// cases, reset abort, and a randomized sweep.
module tb_mult_result_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] product = 16'd0;
  logic        sign = 1'b0;
  logic        busy;
  logic        done;
  logic [19:0] bcd;
  logic        sign_out;

  int errors = 0;
  int checks = 0;

  mult_result_bcd #(.D2W(16), .NDIG(5)) dut (
    .clk(clk), .rst(rst), .start(start), .product(product), .sign(sign),
    .busy(busy), .done(done), .bcd(bcd), .sign_out(sign_out)
  );

  always #5 clk = ~clk;

  // Reference: decimal digits by division, blanking from the highest nonzero digit.
  function automatic logic [19:0] ref_bcd(input int p);
    logic [19:0] r;
    int v;
    int top;
    int d;
    r = '0;
    v = p;
    top = 0;
    for (int i = 0; i < 5; i++) begin
      d = v % 10;
      r[4*i +: 4] = 4'(d);
      if (d != 0) top = i;
      v = v / 10;
    end
`ifdef MULT_BCD_BLANK_EN
    for (int i = 1; i < 5; i++) if (i > top) r[4*i +: 4] = 4'hF;
`endif
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a request accepted while idle produces its result 17 edges later.
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_sign_out = 1'b0;
  logic [19:0] m_bcd = '0;
  int          m_rem = 0;
  int          m_p = 0;
  logic        m_s = 1'b0;

  initial forever begin
    @(posedge clk);
    if (!rst) begin
      m_busy = 1'b0; m_done = 1'b0; m_sign_out = 1'b0; m_bcd = '0; m_rem = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_busy     = 1'b0;
          m_done     = 1'b1;
          m_bcd      = ref_bcd(m_p);
          m_sign_out = m_s && (m_p != 0);
        end
      end else if (start) begin
        m_busy = 1'b1;
        m_rem  = 17;
        m_p    = int'(product);
        m_s    = sign;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_bcd", 32'(bcd), 32'd0);
      chk("rst_sign", 32'(sign_out), 32'd0);
    end else begin
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_done", 32'(done), 32'(m_done));
      chk("cyc_bcd", 32'(bcd), 32'(m_bcd));
      chk("cyc_sign", 32'(sign_out), 32'(m_sign_out));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] p, input logic s);
    product = p;
    sign    = s;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    product = 16'($urandom);
    sign    = 1'($urandom);
  endtask

  // Returns the number of edges from the start edge to the edge after which done is high.
  task automatic wait_done(input bit junk, output int lat);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      start   = (junk && i < 10) ? 1'($urandom) : 1'b0;
      product = 16'($urandom);
      sign    = 1'($urandom);
      tick();
      if (done) begin
        lat = i;
        break;
      end
    end
    start = 1'b0;
    if (lat < 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done expected done within 40 cycles");
    end
  endtask

  int lat;
  logic [15:0] specials [7] = '{16'd0, 16'd9, 16'd10, 16'd99, 16'd100, 16'd65025, 16'd65535};
  logic [15:0] p;
  logic        s;

  initial begin
    repeat (3) tick();
    chk("reset_bcd", 32'(bcd), 32'h0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sign", 32'(sign_out), 32'd0);
    rst = 1'b1;
    repeat (50) tick();
    chk("idle_bcd", 32'(bcd), 32'h0);
    chk("idle_busy", 32'(busy), 32'd0);

    pulse(16'd65535, 1'b0);
    wait_done(1'b0, lat);
    chk("lat_65535", 32'(lat), 32'd17);
    chk("bcd_65535", 32'(bcd), 32'h65535);
    chk("sign_65535", 32'(sign_out), 32'd0);

    pulse(16'd12, 1'b1);
    wait_done(1'b0, lat);
`ifdef MULT_BCD_BLANK_EN
    chk("bcd_12", 32'(bcd), 32'hFFF12);
`else
    chk("bcd_12", 32'(bcd), 32'h00012);
`endif
    chk("sign_12", 32'(sign_out), 32'd1);

    pulse(16'd0, 1'b1);
    wait_done(1'b0, lat);
`ifdef MULT_BCD_BLANK_EN
    chk("bcd_0", 32'(bcd), 32'hFFFF0);
`else
    chk("bcd_0", 32'(bcd), 32'h00000);
`endif
    chk("sign_0", 32'(sign_out), 32'd0);

    pulse(16'd999, 1'b0);
    repeat (3) tick();
    pulse(16'd1, 1'b0);
    wait_done(1'b0, lat);
`ifdef MULT_BCD_BLANK_EN
    chk("bcd_999", 32'(bcd), 32'hFF999);
`else
    chk("bcd_999", 32'(bcd), 32'h00999);
`endif
    pulse(16'd1, 1'b0);
    wait_done(1'b0, lat);
    chk("lat_b2b", 32'(lat), 32'd17);
`ifdef MULT_BCD_BLANK_EN
    chk("bcd_1", 32'(bcd), 32'hFFFF1);
`else
    chk("bcd_1", 32'(bcd), 32'h00001);
`endif

    pulse(16'd40000, 1'b1);
    repeat (7) tick();
    rst = 1'b0;
    #1;
    chk("abort_bcd", 32'(bcd), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (3) tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end

    pulse(16'd255, 1'b1);
    wait_done(1'b0, lat);
`ifdef MULT_BCD_BLANK_EN
    chk("bcd_255", 32'(bcd), 32'hFF255);
`else
    chk("bcd_255", 32'(bcd), 32'h00255);
`endif
    chk("sign_255", 32'(sign_out), 32'd1);

    for (int n = 0; n < 1000; n++) begin
      p = (n < 7) ? specials[n] : 16'($urandom);
      s = 1'($urandom);
      pulse(p, s);
      wait_done(1'b1, lat);
      chk("sweep_lat", 32'(lat), 32'd17);
      chk("sweep_bcd", 32'(bcd), 32'(ref_bcd(int'(p))));
      chk("sweep_sign", 32'(sign_out), 32'(s && (p != 16'd0)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
